// File: rtl/mop_issue_queue.sv
// In-order micro-op issue queue between the x86 cracker and rename/dispatch.
// Optional end-of-instruction marks are compiled in with MOP_ISSUE_QUEUE_EOI_EN.
module mop_issue_queue #(
  parameter int MOP_W       = 64,
  parameter int MAX_MOP_CNT = 4,
  parameter int ISSUE_W     = 2,
  parameter int DEPTH       = 16,
  localparam int CNT_W      = $clog2(MAX_MOP_CNT + 1),
  localparam int TAKE_W     = $clog2(ISSUE_W + 1),
  localparam int OCC_W      = $clog2(DEPTH + 1),
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CNT_W-1:0]             in_cnt,
  input  logic                         in_err,
  input  logic [MAX_MOP_CNT*MOP_W-1:0] in_mops,
  output logic [TAKE_W-1:0]            out_cnt,
  output logic [ISSUE_W*MOP_W-1:0]     out_mops,
  output logic [ISSUE_W-1:0]           out_eoi,
  input  logic [TAKE_W-1:0]            out_take,
  output logic                         err,
  output logic [OCC_W-1:0]             occupancy
);

  // Handshake: a group transfers on a rising edge where in_valid & in_ready & !flush.
  // in_ready depends only on registered occupancy, so a full group always fits even
  // if the backend takes nothing that cycle.

  logic [MOP_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             err_q, err_d;
  logic [OCC_W-1:0] free_slots;
  logic             accept;
  logic             bad_grp;
  logic [CNT_W-1:0] enq_cnt;
  logic [TAKE_W-1:0] avail;
  logic [TAKE_W-1:0] take_eff;

  assign free_slots = OCC_W'(DEPTH) - occ_q;
  assign in_ready   = free_slots >= OCC_W'(MAX_MOP_CNT);
  assign accept     = in_valid & in_ready & ~flush;
  // An oversized count is as untrustworthy as an explicit crack error.
  assign bad_grp    = in_err | (in_cnt > CNT_W'(MAX_MOP_CNT));
  assign enq_cnt    = (accept & ~bad_grp) ? in_cnt : '0;

  assign avail      = (occ_q >= OCC_W'(ISSUE_W)) ? TAKE_W'(ISSUE_W) : TAKE_W'(occ_q);
  assign take_eff   = (out_take > avail) ? avail : out_take;

  assign out_cnt    = avail;
  assign err        = err_q;
  assign occupancy  = occ_q;

  always_comb begin
    head_d = head_q + PTR_W'(take_eff);
    tail_d = tail_q + PTR_W'(enq_cnt);
    occ_d  = occ_q + OCC_W'(enq_cnt) - OCC_W'(take_eff);
    err_d  = err_q | (accept & bad_grp);
    if (flush) begin
      head_d = tail_q;
      tail_d = tail_q;
      occ_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      err_q  <= err_d;
    end
  end

  // Payload storage needs no reset; lanes beyond out_cnt are masked on the output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < MAX_MOP_CNT; i++) begin
        if (CNT_W'(i) < enq_cnt) begin
          mem_q[tail_q + PTR_W'(i)] <= in_mops[i*MOP_W +: MOP_W];
        end
      end
    end
  end

`ifdef MOP_ISSUE_QUEUE_EOI_EN
  logic [DEPTH-1:0] eoi_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      eoi_q <= '0;
    end else begin
      for (int i = 0; i < MAX_MOP_CNT; i++) begin
        if (CNT_W'(i) < enq_cnt) begin
          eoi_q[tail_q + PTR_W'(i)] <= (CNT_W'(i) == (enq_cnt - CNT_W'(1)));
        end
      end
    end
  end
`endif

  always_comb begin
    out_mops = '0;
    out_eoi  = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      if (TAKE_W'(i) < avail) begin
        out_mops[i*MOP_W +: MOP_W] = mem_q[head_q + PTR_W'(i)];
`ifdef MOP_ISSUE_QUEUE_EOI_EN
        out_eoi[i] = eoi_q[head_q + PTR_W'(i)];
`endif
      end
    end
  end

  // Over-take is clamped in hardware; the warning flags the offending backend.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      assert (out_take <= avail)
        else $warning("mop_issue_queue: out_take %0d exceeds out_cnt %0d", out_take, avail);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (occ_q <= OCC_W'(DEPTH))
        else $error("mop_issue_queue: occupancy %0d above depth", occ_q);
    end
  end

endmodule

// File: tb/tb_mop_issue_queue.sv
// Directed bench for mop_issue_queue: reset, ordering, fill/backpressure, wrap,
// nop/error groups, flush and over-take clamping.
module tb_mop_issue_queue;

`ifdef MOP_ISSUE_QUEUE_EOI_EN
  localparam bit EOI_EN = 1'b1;
`else
  localparam bit EOI_EN = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_cnt;
  logic         in_err;
  logic [255:0] in_mops;
  logic [1:0]   out_cnt;
  logic [127:0] out_mops;
  logic [1:0]   out_eoi;
  logic [1:0]   out_take;
  logic         err;
  logic [4:0]   occupancy;

  int vectors;
  int miscompares;

  logic [63:0] exp_q[$];
  logic        exp_eoi_q[$];

  mop_issue_queue dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_cnt(in_cnt),
    .in_err(in_err), .in_mops(in_mops),
    .out_cnt(out_cnt), .out_mops(out_mops), .out_eoi(out_eoi),
    .out_take(out_take), .err(err), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input int t);
    return {32'hC0DE_0000, 32'(t)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_cnt   = 3'd0;
    in_err   = 1'b0;
    out_take = 2'd0;
    flush    = 1'b0;
  endtask

  task automatic set_grp(input int cnt, input int base, input logic e);
    in_valid = 1'b1;
    in_cnt   = 3'(cnt);
    in_err   = e;
    for (int i = 0; i < 4; i++) in_mops[i*64 +: 64] = mk(base + i);
  endtask

  task automatic do_reset();
    idle();
    in_mops = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (occupancy !== 5'd0) begin miscompares++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    vectors++; if (out_cnt !== 2'd0) begin miscompares++; $display("FAIL reset_out_cnt got %0d exp 0", out_cnt); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", err); end
    vectors++; if (out_eoi !== 2'b00) begin miscompares++; $display("FAIL reset_eoi got %b exp 00", out_eoi); end
    vectors++; if (out_mops !== 128'd0) begin miscompares++; $display("FAIL reset_mops got %h exp 0", out_mops); end
  endtask

  task automatic test_basic();
    do_reset();
    set_grp(3, 'h100, 1'b0);
    tick();
    idle();
    vectors++; if (occupancy !== 5'd3) begin miscompares++; $display("FAIL basic_occ got %0d exp 3", occupancy); end
    vectors++; if (out_cnt !== 2'd2) begin miscompares++; $display("FAIL basic_cnt got %0d exp 2", out_cnt); end
    vectors++; if (out_mops !== {mk('h101), mk('h100)}) begin miscompares++; $display("FAIL basic_lanes got %h exp A0/A1", out_mops); end
    vectors++; if (out_eoi !== 2'b00) begin miscompares++; $display("FAIL basic_eoi0 got %b exp 00", out_eoi); end
    out_take = 2'd2;
    tick();
    out_take = 2'd0;
    vectors++; if (out_cnt !== 2'd1) begin miscompares++; $display("FAIL basic_cnt2 got %0d exp 1", out_cnt); end
    vectors++; if (out_mops !== {64'd0, mk('h102)}) begin miscompares++; $display("FAIL basic_lane_a2 got %h exp A2", out_mops); end
    vectors++; if (out_eoi !== (EOI_EN ? 2'b01 : 2'b00)) begin miscompares++; $display("FAIL basic_eoi1 got %b exp %b", out_eoi, EOI_EN ? 2'b01 : 2'b00); end
    vectors++; if (occupancy !== 5'd1) begin miscompares++; $display("FAIL basic_occ2 got %0d exp 1", occupancy); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int g = 0; g < 4; g++) begin
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready%0d got %b exp 1", g, in_ready); end
      set_grp(4, 'h200 + 4*g, 1'b0);
      tick();
    end
    vectors++; if (occupancy !== 5'd16) begin miscompares++; $display("FAIL fill_full got %0d exp 16", occupancy); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_ready_full got %b exp 0", in_ready); end
    set_grp(4, 'h210, 1'b0);
    tick();
    vectors++; if (occupancy !== 5'd16) begin miscompares++; $display("FAIL fill_held got %0d exp 16", occupancy); end
    out_take = 2'd2;
    tick();
    vectors++; if (occupancy !== 5'd14 || in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_14 got occ %0d rdy %b exp 14/0", occupancy, in_ready); end
    tick();
    vectors++; if (occupancy !== 5'd12 || in_ready !== 1'b1) begin miscompares++; $display("FAIL fill_12 got occ %0d rdy %b exp 12/1", occupancy, in_ready); end
    tick();
    idle();
    vectors++; if (occupancy !== 5'd14) begin miscompares++; $display("FAIL fill_enq_deq got %0d exp 14", occupancy); end
    vectors++; if (out_mops !== {mk('h207), mk('h206)}) begin miscompares++; $display("FAIL fill_order got %h exp 206/207", out_mops); end
    vectors++; if (out_eoi !== (EOI_EN ? 2'b10 : 2'b00)) begin miscompares++; $display("FAIL fill_eoi got %b exp %b", out_eoi, EOI_EN ? 2'b10 : 2'b00); end
    out_take = 2'd2;
    for (int k = 0; k < 7; k++) tick();
    idle();
    vectors++; if (occupancy !== 5'd0) begin miscompares++; $display("FAIL fill_drain got %0d exp 0", occupancy); end
  endtask

  task automatic test_wrap();
    int occ_m;
    int tag;
    int exp_cnt;
    logic exp_rdy;
    logic [127:0] exp_v;
    logic [1:0] exp_e;
    do_reset();
    exp_q.delete();
    exp_eoi_q.delete();
    occ_m = 0;
    tag = 'h300;
    for (int cyc = 0; cyc < 60; cyc++) begin
      exp_cnt = (occ_m < 2) ? occ_m : 2;
      exp_rdy = (16 - occ_m) >= 4;
      exp_v = '0;
      exp_e = '0;
      for (int i = 0; i < exp_cnt; i++) begin
        exp_v[i*64 +: 64] = exp_q[i];
        exp_e[i] = EOI_EN & exp_eoi_q[i];
      end
      vectors++; if (occupancy !== 5'(occ_m)) begin miscompares++; $display("FAIL wrap_occ c%0d got %0d exp %0d", cyc, occupancy, occ_m); end
      vectors++; if (in_ready !== exp_rdy) begin miscompares++; $display("FAIL wrap_ready c%0d got %b exp %b", cyc, in_ready, exp_rdy); end
      vectors++; if (out_cnt !== 2'(exp_cnt) || out_mops !== exp_v) begin miscompares++; $display("FAIL wrap_lanes c%0d got %0d/%h exp %0d/%h", cyc, out_cnt, out_mops, exp_cnt, exp_v); end
      vectors++; if (out_eoi !== exp_e) begin miscompares++; $display("FAIL wrap_eoi c%0d got %b exp %b", cyc, out_eoi, exp_e); end
      if (cyc < 40) set_grp(3, tag, 1'b0);
      else in_valid = 1'b0;
      out_take = 2'(exp_cnt);
      tick();
      for (int i = 0; i < exp_cnt; i++) begin
        void'(exp_q.pop_front());
        void'(exp_eoi_q.pop_front());
      end
      occ_m -= exp_cnt;
      if (cyc < 40 && exp_rdy) begin
        for (int i = 0; i < 3; i++) begin
          exp_q.push_back(mk(tag + i));
          exp_eoi_q.push_back(i == 2);
        end
        tag += 3;
        occ_m += 3;
      end
    end
    idle();
    vectors++; if (occupancy !== 5'd0 || occ_m != 0) begin miscompares++; $display("FAIL wrap_empty got %0d model %0d exp 0", occupancy, occ_m); end
  endtask

  task automatic test_nop_err();
    do_reset();
    set_grp(2, 'h400, 1'b1);
    tick();
    idle();
    vectors++; if (err !== 1'b1 || occupancy !== 5'd0) begin miscompares++; $display("FAIL err_set got err %b occ %0d exp 1/0", err, occupancy); end
    do_reset();
    set_grp(2, 'h410, 1'b0);
    tick();
    set_grp(0, 'h420, 1'b0);
    tick();
    vectors++; if (occupancy !== 5'd2 || err !== 1'b0) begin miscompares++; $display("FAIL nop got occ %0d err %b exp 2/0", occupancy, err); end
    set_grp(7, 'h430, 1'b0);
    tick();
    vectors++; if (occupancy !== 5'd2 || err !== 1'b1) begin miscompares++; $display("FAIL overcnt got occ %0d err %b exp 2/1", occupancy, err); end
    set_grp(3, 'h440, 1'b1);
    tick();
    set_grp(1, 'h450, 1'b0);
    tick();
    idle();
    vectors++; if (occupancy !== 5'd3 || err !== 1'b1) begin miscompares++; $display("FAIL err_sticky got occ %0d err %b exp 3/1", occupancy, err); end
    vectors++; if (out_mops !== {mk('h411), mk('h410)}) begin miscompares++; $display("FAIL err_order got %h exp 410/411", out_mops); end
    flush = 1'b1;
    tick();
    idle();
    vectors++; if (occupancy !== 5'd0 || err !== 1'b1) begin miscompares++; $display("FAIL flush_keeps_err got occ %0d err %b exp 0/1", occupancy, err); end
  endtask

  task automatic test_flush();
    do_reset();
    set_grp(4, 'h500, 1'b0);
    tick();
    set_grp(3, 'h510, 1'b0);
    tick();
    idle();
    vectors++; if (occupancy !== 5'd7) begin miscompares++; $display("FAIL flush_pre got %0d exp 7", occupancy); end
    set_grp(2, 'h520, 1'b0);
    flush = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready got %b exp 1", in_ready); end
    tick();
    idle();
    vectors++; if (occupancy !== 5'd0 || out_cnt !== 2'd0 || out_mops !== 128'd0) begin miscompares++; $display("FAIL flush_empty got occ %0d cnt %0d mops %h", occupancy, out_cnt, out_mops); end
    set_grp(1, 'h530, 1'b0);
    tick();
    idle();
    vectors++; if (occupancy !== 5'd1 || out_mops !== {64'd0, mk('h530)}) begin miscompares++; $display("FAIL flush_after got occ %0d mops %h exp 1/530", occupancy, out_mops); end
  endtask

  task automatic test_over_take();
    do_reset();
    set_grp(2, 'h600, 1'b0);
    tick();
    idle();
    out_take = 2'd1;
    tick();
    vectors++; if (out_cnt !== 2'd1 || out_mops !== {64'd0, mk('h601)}) begin miscompares++; $display("FAIL ot_pre got cnt %0d mops %h exp 1/601", out_cnt, out_mops); end
    out_take = 2'd2;
    tick();
    idle();
    vectors++; if (occupancy !== 5'd0 || out_cnt !== 2'd0) begin miscompares++; $display("FAIL ot_clamp got occ %0d cnt %0d exp 0/0", occupancy, out_cnt); end
    set_grp(2, 'h610, 1'b0);
    tick();
    idle();
    vectors++; if (out_mops !== {mk('h611), mk('h610)}) begin miscompares++; $display("FAIL ot_head got %h exp 610/611", out_mops); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    in_mops = '0;
    idle();
    test_reset();
    test_basic();
    test_fill();
    test_wrap();
    test_nop_err();
    test_flush();
    test_over_take();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
